// File: rtl/ring_pkg.sv
// Shared types for the ring request agent.
// Packet encodings, field widths and the queued request entry.
package ring_pkg;

  localparam int ADDR_W = 36;
  localparam int DATA_W = 512;
  localparam int ID_W   = 4;

  typedef enum logic [2:0] {
    PKT_EMPTY   = 3'b000,
    PKT_WR_REQ  = 3'b001,
    PKT_RD_REQ  = 3'b011,
    PKT_WR_ACK  = 3'b101,
    PKT_RD_RESP = 3'b110
  } pkt_type_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ring_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } agent_state_e;

endpackage

// File: rtl/ring_req_fifo.sv
// Synchronous FIFO of generic entries.
// Head entry is visible on rdata whenever the FIFO is non-empty.
module ring_req_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T             mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ring_request_agent.sv
// Ring node client adapter: queues client requests, injects them into
// empty ring slots and returns the matching controller response.
module ring_request_agent
  import ring_pkg::*;
#(
  parameter int NODE_ID = 1,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
  input  logic [ADDR_W-1:0] addr_req_out,
  input  logic [DATA_W-1:0] data_req_out,
  input  logic [ID_W-1:0]   id_req_out,
  input  logic [2:0]        packet_type_req_out,
  output logic              overwrite,
  output logic [ADDR_W-1:0] addr_req_in,
  output logic [DATA_W-1:0] data_req_in,
  output logic [ID_W-1:0]   id_req_in,
  output logic [2:0]        packet_type_req_in,
  output logic              err_timeout,
  output logic [7:0]        stale_cnt
);

  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);
  localparam logic [15:0]     TMAX  = 16'(TIMEOUT - 1);

  agent_state_e  state_q, state_d;
  logic          reissue_q, reissue_d;
  ring_req_t     cur_q, cur_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    stale_q, stale_d;

  ring_req_t     fifo_in, fifo_head, head;
  logic          fifo_full, fifo_empty, push, pop;
  logic [$clog2(QDEPTH):0] fifo_cnt;

  logic slot_empty, own_resp, match;
  logic drain, inject, clear;

  assign fifo_in   = '{we: req_we, addr: req_addr, data: req_data};
  assign req_ready = rst & ~fifo_full;
  assign push      = req_valid & req_ready;
  assign stale_cnt = stale_q;

  ring_req_fifo #(
    .DEPTH (QDEPTH),
    .T     (ring_req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign slot_empty = (packet_type_req_out == PKT_EMPTY);
  assign own_resp   = (id_req_out == MY_ID) &&
                      (packet_type_req_out == PKT_WR_ACK ||
                       packet_type_req_out == PKT_RD_RESP);
  assign match      = (id_req_out == MY_ID) &&
                      (packet_type_req_out ==
                       (cur_q.we ? PKT_WR_ACK : PKT_RD_RESP));
  assign head       = reissue_q ? cur_q : fifo_head;

  always_comb begin
    state_d            = state_q;
    reissue_d          = reissue_q;
    cur_d              = cur_q;
    timer_d            = timer_q;
    stale_d            = stale_q;
    drain              = 1'b0;
    inject             = 1'b0;
    clear              = 1'b0;
    pop                = 1'b0;
    resp_valid         = 1'b0;
    resp_we            = 1'b0;
    resp_addr          = '0;
    resp_data          = '0;
    err_timeout        = 1'b0;
    overwrite          = 1'b0;
    addr_req_in        = '0;
    data_req_in        = '0;
    id_req_in          = '0;
    packet_type_req_in = PKT_EMPTY;
    unique case (state_q)
      ST_IDLE: begin
        drain = own_resp;
        if (fifo_cnt != '0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        drain = own_resp;
        if (!own_resp && slot_empty) begin
          inject    = 1'b1;
          pop       = ~reissue_q;
          cur_d     = head;
          reissue_d = 1'b0;
          timer_d   = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (match) begin
          clear      = 1'b1;
          resp_valid = 1'b1;
          resp_we    = cur_q.we;
          resp_addr  = addr_req_out;
          resp_data  = cur_q.we ? '0 : data_req_out;
          state_d    = fifo_empty ? ST_IDLE : ST_ISSUE;
        end else if (timer_q == TMAX) begin
          err_timeout = 1'b1;
          reissue_d   = 1'b1;
          state_d     = ST_ISSUE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (drain) begin
      clear = 1'b1;
      if (stale_q != '1) stale_d = stale_q + 1'b1;
    end
    if (clear) overwrite = 1'b1;
    if (inject) begin
      overwrite          = 1'b1;
      packet_type_req_in = head.we ? PKT_WR_REQ : PKT_RD_REQ;
      id_req_in          = MY_ID;
      addr_req_in        = head.addr;
      data_req_in        = head.data;
    end
    // Keep the slot untouched while reset is held, even if a response sits there.
    if (!rst) begin
      overwrite          = 1'b0;
      addr_req_in        = '0;
      data_req_in        = '0;
      id_req_in          = '0;
      packet_type_req_in = PKT_EMPTY;
      resp_valid         = 1'b0;
      resp_we            = 1'b0;
      resp_addr          = '0;
      resp_data          = '0;
      err_timeout        = 1'b0;
      pop                = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      reissue_q <= 1'b0;
      cur_q     <= '0;
      timer_q   <= '0;
      stale_q   <= '0;
    end else begin
      state_q   <= state_d;
      reissue_q <= reissue_d;
      cur_q     <= cur_d;
      timer_q   <= timer_d;
      stale_q   <= stale_d;
    end
  end

endmodule

// File: tb/tb_ring_request_agent.sv
// Directed bench for ring_request_agent (NODE_ID 1, depth 4, timeout 8).
// Slot contents are driven by hand; outputs sampled mid-cycle.
module tb_ring_request_agent;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [35:0]   req_addr;
  logic [511:0]  req_data;
  logic          resp_valid;
  logic          resp_we;
  logic [35:0]   resp_addr;
  logic [511:0]  resp_data;
  logic [35:0]   addr_req_out;
  logic [511:0]  data_req_out;
  logic [3:0]    id_req_out;
  logic [2:0]    packet_type_req_out;
  logic          overwrite;
  logic [35:0]   addr_req_in;
  logic [511:0]  data_req_in;
  logic [3:0]    id_req_in;
  logic [2:0]    packet_type_req_in;
  logic          err_timeout;
  logic [7:0]    stale_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ring_request_agent #(
    .NODE_ID (1),
    .QDEPTH  (4),
    .TIMEOUT (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_we              (req_we),
    .req_addr            (req_addr),
    .req_data            (req_data),
    .resp_valid          (resp_valid),
    .resp_we             (resp_we),
    .resp_addr           (resp_addr),
    .resp_data           (resp_data),
    .addr_req_out        (addr_req_out),
    .data_req_out        (data_req_out),
    .id_req_out          (id_req_out),
    .packet_type_req_out (packet_type_req_out),
    .overwrite           (overwrite),
    .addr_req_in         (addr_req_in),
    .data_req_in         (data_req_in),
    .id_req_in           (id_req_in),
    .packet_type_req_in  (packet_type_req_in),
    .err_timeout         (err_timeout),
    .stale_cnt           (stale_cnt)
  );

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [2:0] t, input logic [3:0] id,
                      input logic [35:0] a, input logic [511:0] d);
    packet_type_req_out = t;
    id_req_out          = id;
    addr_req_out        = a;
    data_req_out        = d;
    #1;
  endtask

  task automatic req(input logic v, input logic we,
                     input logic [35:0] a, input logic [511:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic chk_inject(input string tag, input logic [2:0] t,
                            input logic [35:0] a);
    chk({tag, "_ow"}, 512'(overwrite), 512'd1);
    chk({tag, "_type"}, 512'(packet_type_req_in), 512'(t));
    chk({tag, "_id"}, 512'(id_req_in), 512'd1);
    chk({tag, "_addr"}, 512'(addr_req_in), 512'(a));
  endtask

  task automatic chk_consume(input string tag);
    chk({tag, "_ow"}, 512'(overwrite), 512'd1);
    chk({tag, "_type"}, 512'(packet_type_req_in), 512'd0);
    chk({tag, "_id"}, 512'(id_req_in), 512'd0);
    chk({tag, "_addr"}, 512'(addr_req_in), 512'd0);
    chk({tag, "_data"}, data_req_in, 512'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req(1'b0, 1'b0, '0, '0);
    slot(3'b000, 4'd0, '0, '0);
    cyc();
    cyc();
    chk("rst_ready", 512'(req_ready), 512'd0);
    chk("rst_ow", 512'(overwrite), 512'd0);
    chk("rst_resp", 512'(resp_valid), 512'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 512'(req_ready), 512'd1);
    chk("rel_stale", 512'(stale_cnt), 512'd0);
    chk("rel_err", 512'(err_timeout), 512'd0);

    // single write
    req(1'b1, 1'b1, 36'h0_1234_5678, 512'hA5);
    cyc();
    req(1'b0, 1'b0, '0, '0);
    #1;
    chk("wr_idle_ow", 512'(overwrite), 512'd0);
    cyc();
    chk_inject("wr_inj", 3'b001, 36'h0_1234_5678);
    chk("wr_inj_data", data_req_in, 512'hA5);
    cyc();
    slot(3'b101, 4'd1, 36'h0_1234_5678, 512'hDEAD);
    chk("wr_rv", 512'(resp_valid), 512'd1);
    chk("wr_rwe", 512'(resp_we), 512'd1);
    chk("wr_raddr", 512'(resp_addr), 512'h0_1234_5678);
    chk("wr_rdata", resp_data, 512'd0);
    chk_consume("wr_cons");
    cyc();
    slot(3'b000, 4'd0, '0, '0);
    chk("wr_rv_end", 512'(resp_valid), 512'd0);

    // read behind 5 busy slots, then a foreign response
    slot(3'b011, 4'd2, 36'h777, 512'h1);
    req(1'b1, 1'b0, 36'h42, '0);
    cyc();
    req(1'b0, 1'b0, '0, '0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rd_busy%0d", i), 512'(overwrite), 512'd0);
      cyc();
    end
    slot(3'b000, 4'd0, '0, '0);
    chk_inject("rd_inj", 3'b011, 36'h42);
    cyc();
    slot(3'b110, 4'd2, 36'h42, 512'h42);
    chk("frgn_ow", 512'(overwrite), 512'd0);
    chk("frgn_rv", 512'(resp_valid), 512'd0);
    cyc();
    slot(3'b110, 4'd1, 36'h42, 512'h42);
    chk("rd_rv", 512'(resp_valid), 512'd1);
    chk("rd_rwe", 512'(resp_we), 512'd0);
    chk("rd_rdata", resp_data, 512'h42);
    chk_consume("rd_cons");
    cyc();
    slot(3'b000, 4'd0, '0, '0);

    // fill FIFO while one write is outstanding
    req(1'b1, 1'b1, 36'h100, 512'h100);
    cyc();
    req(1'b0, 1'b0, '0, '0);
    cyc();
    chk_inject("f_inj0", 3'b001, 36'h100);
    cyc();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, i[0], 36'h101 + 36'(i), 512'(i));
      cyc();
    end
    chk("f_full_ready", 512'(req_ready), 512'd0);
    req(1'b1, 1'b1, 36'h105, 512'h5);
    cyc();
    req(1'b0, 1'b0, '0, '0);
    slot(3'b101, 4'd1, 36'h100, '0);
    chk("f_rv0", 512'(resp_valid), 512'd1);
    cyc();
    slot(3'b000, 4'd0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      chk_inject($sformatf("f_inj%0d", k + 1),
                 k[0] ? 3'b001 : 3'b011, 36'h101 + 36'(k));
      cyc();
      slot(k[0] ? 3'b101 : 3'b110, 4'd1, 36'h101 + 36'(k), 512'(k + 7));
      chk($sformatf("f_rv%0d", k + 1), 512'(resp_valid), 512'd1);
      chk($sformatf("f_raddr%0d", k + 1), 512'(resp_addr),
          512'h101 + 512'(k));
      cyc();
      slot(3'b000, 4'd0, '0, '0);
    end
    chk("f_ready_end", 512'(req_ready), 512'd1);
    cyc();
    chk("f_no5th", 512'(overwrite), 512'd0);

    // timeout and retry, then the duplicate response is drained
    req(1'b1, 1'b0, 36'h200, '0);
    cyc();
    req(1'b0, 1'b0, '0, '0);
    cyc();
    chk_inject("to_inj", 3'b011, 36'h200);
    cyc();
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("to_quiet%0d", i), 512'(err_timeout), 512'd0);
      cyc();
    end
    chk("to_err", 512'(err_timeout), 512'd1);
    chk("to_err_ow", 512'(overwrite), 512'd0);
    cyc();
    chk("to_err_end", 512'(err_timeout), 512'd0);
    chk_inject("to_reinj", 3'b011, 36'h200);
    cyc();
    slot(3'b110, 4'd1, 36'h200, 512'h55);
    chk("to_rv", 512'(resp_valid), 512'd1);
    chk("to_rdata", resp_data, 512'h55);
    cyc();
    slot(3'b110, 4'd1, 36'h200, 512'h55);
    chk("to_dup_rv", 512'(resp_valid), 512'd0);
    chk_consume("to_drain");
    cyc();
    slot(3'b000, 4'd0, '0, '0);
    chk("to_stale", 512'(stale_cnt), 512'd1);

    // reset while waiting
    req(1'b1, 1'b1, 36'h300, 512'h3);
    cyc();
    req(1'b0, 1'b0, '0, '0);
    cyc();
    chk_inject("rw_inj", 3'b001, 36'h300);
    cyc();
    rst = 1'b0;
    slot(3'b101, 4'd1, 36'h300, '0);
    chk("rw_ow", 512'(overwrite), 512'd0);
    chk("rw_rv", 512'(resp_valid), 512'd0);
    chk("rw_ready", 512'(req_ready), 512'd0);
    chk("rw_stale0", 512'(stale_cnt), 512'd0);
    cyc();
    rst = 1'b1;
    #1;
    chk("rw_drain_rv", 512'(resp_valid), 512'd0);
    chk_consume("rw_drain");
    cyc();
    slot(3'b000, 4'd0, '0, '0);
    chk("rw_stale1", 512'(stale_cnt), 512'd1);
    chk("rw_idle_ow", 512'(overwrite), 512'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
